// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmitter and receiver.
// Holds the FSM state encoding, the line-level bit constants and the even-parity helper.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..CLKS_PER_BIT-1 and wraps; bit_done flags the last cycle of a bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    bit_done = cnt_q == W'(CLKS_PER_BIT - 1);
    cnt_d    = (restart || bit_done) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: REQ/ACK byte input serialised LSB-first onto XMT as start, 8 data, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       XMIT_REQ,
  input  logic [7:0] XMIT_DATA,
  output logic       XMIT_ACK,
  output logic       XMIT_BUSY,
  output logic       XMT
);
  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        xmt_q, xmt_d;
  logic        ack_q, ack_d;
  logic        bit_done;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .clr      (clr),
    .restart  (state_q == ST_IDLE),
    .bit_done (bit_done)
  );
  // The byte is rotated, not shifted, so its parity is still available after the last data bit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    xmt_d   = xmt_q;
    ack_d   = (ack_q && !XMIT_REQ) ? 1'b0 : ack_q;
    case (state_q)
      ST_IDLE: begin
        xmt_d = UART_STOP_BIT;
        if (XMIT_REQ && !ack_q) begin
          shift_d = XMIT_DATA;
          ack_d   = 1'b1;
          state_d = ST_START;
          xmt_d   = UART_START_BIT;
        end
      end
      ST_START: if (bit_done) begin
        state_d = ST_DATA;
        xmt_d   = shift_q[0];
        idx_d   = '0;
      end
      ST_DATA: if (bit_done) begin
        if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
          xmt_d   = even_parity(shift_q);
`else
          state_d = ST_STOP;
          xmt_d   = UART_STOP_BIT;
`endif
        end else begin
          shift_d = {shift_q[0], shift_q[7:1]};
          xmt_d   = shift_q[1];
          idx_d   = idx_q + 1'b1;
        end
      end
      ST_PARITY: if (bit_done) begin
        state_d = ST_STOP;
        xmt_d   = UART_STOP_BIT;
      end
      ST_STOP: if (bit_done) state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        xmt_d   = UART_STOP_BIT;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      xmt_q   <= UART_STOP_BIT;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      xmt_q   <= xmt_d;
      ack_q   <= ack_d;
    end
  end
  assign XMT       = xmt_q;
  assign XMIT_ACK  = ack_q;
  assign XMIT_BUSY = state_q != ST_IDLE;
endmodule
